// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB master bridge: one outstanding transfer, four decoded APB slots.
// Define ERR_RESP_EN to answer out-of-range transfers with a two-cycle ERROR response.
module ahb_apb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned SLOT_BITS = 26
) (
  input  logic        clk,
  input  logic        Hrst,
  input  logic [31:0] Haddr,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic [2:0]  Hsize,
  input  logic [2:0]  Hburst,
  input  logic [31:0] Hwdata,
  input  logic        Hreadyin,
  output logic        Hreadyout,
  output logic [1:0]  Hresp,
  output logic [31:0] Hrdata,
  output logic [3:0]  Psel,
  output logic        Penable,
  output logic        Pwrite,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  input  logic [31:0] Prdata
);

  typedef enum logic [2:0] {
    StIdle, StRead, StRenable, StWwait, StWrite, StWenable, StErr1, StErr2
  } state_e;

  // 33-bit bounds so a region ending at 4 GB cannot wrap.
  localparam logic [32:0] RegionLo = {1'b0, BASE_ADDR};
  localparam logic [32:0] RegionHi = RegionLo + (33'd4 << SLOT_BITS);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [2:0]  hburst_q, hburst_d;
  logic [3:0]  psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic        hreadyout_q, hreadyout_d;
  logic [1:0]  hresp_q, hresp_d;
  logic [1:0]  slot_d;
  logic        in_range;
  logic        valid;
  logic        unused_ctrl;

  assign in_range = ({1'b0, Haddr} >= RegionLo) && ({1'b0, Haddr} < RegionHi);
  assign valid    = Hreadyin & Htrans[1] & in_range;

  // Size/burst are recorded but every beat is a plain word access.
  assign unused_ctrl = ^{hsize_q, hburst_q, Htrans[0]};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pwdata_d = pwdata_q;
    hsize_d  = hsize_q;
    hburst_d = hburst_q;
    case (state_q)
      StIdle, StRenable, StWenable: begin
        if (valid) begin
          state_d  = Hwrite ? StWwait : StRead;
          addr_d   = Haddr;
          hsize_d  = Hsize;
          hburst_d = Hburst;
        end
`ifdef ERR_RESP_EN
        else if (Hreadyin & Htrans[1]) begin
          state_d = StErr1;
        end
`endif
        else begin
          state_d = StIdle;
        end
      end
      StRead:    state_d = StRenable;
      StWwait: begin
        pwdata_d = Hwdata;
        state_d  = StWrite;
      end
      StWrite:   state_d = StWenable;
      StErr1:    state_d = StErr2;
      StErr2:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Output flops are loaded from the next state so the APB side is purely registered.
  assign slot_d = addr_d[SLOT_BITS+1:SLOT_BITS];

  always_comb begin
    psel_d      = 4'b0000;
    penable_d   = 1'b0;
    pwrite_d    = 1'b0;
    hreadyout_d = 1'b1;
    hresp_d     = 2'b00;
    case (state_d)
      StRead: begin
        psel_d      = 4'b0001 << slot_d;
        hreadyout_d = 1'b0;
      end
      StRenable: begin
        psel_d    = 4'b0001 << slot_d;
        penable_d = 1'b1;
      end
      StWwait:   hreadyout_d = 1'b0;
      StWrite: begin
        psel_d      = 4'b0001 << slot_d;
        pwrite_d    = 1'b1;
        hreadyout_d = 1'b0;
      end
      StWenable: begin
        psel_d    = 4'b0001 << slot_d;
        pwrite_d  = 1'b1;
        penable_d = 1'b1;
      end
      StErr1: begin
        hresp_d     = 2'b01;
        hreadyout_d = 1'b0;
      end
      StErr2:    hresp_d = 2'b01;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge Hrst) begin
    if (Hrst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      pwdata_q    <= '0;
      hsize_q     <= '0;
      hburst_q    <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      pwdata_q    <= pwdata_d;
      hsize_q     <= hsize_d;
      hburst_q    <= hburst_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign Psel      = psel_q;
  assign Penable   = penable_q;
  assign Pwrite    = pwrite_q;
  assign Paddr     = addr_q;
  assign Pwdata    = pwdata_q;
  assign Hreadyout = hreadyout_q;
  assign Hresp     = hresp_q;
  assign Hrdata    = Prdata;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge: writes, reads, back-to-back, ignored and
// out-of-range transfers, asynchronous reset mid-access.
module tb_ahb_apb_bridge;

  logic        clk = 1'b0;
  logic        Hrst;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic        Hwrite;
  logic [2:0]  Hsize;
  logic [2:0]  Hburst;
  logic [31:0] Hwdata;
  logic        Hreadyin;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [3:0]  Psel;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] Prdata;

  int n_total = 0;
  int n_bad   = 0;

  ahb_apb_bridge dut (
    .clk       (clk),
    .Hrst      (Hrst),
    .Haddr     (Haddr),
    .Htrans    (Htrans),
    .Hwrite    (Hwrite),
    .Hsize     (Hsize),
    .Hburst    (Hburst),
    .Hwdata    (Hwdata),
    .Hreadyin  (Hreadyin),
    .Hreadyout (Hreadyout),
    .Hresp     (Hresp),
    .Hrdata    (Hrdata),
    .Psel      (Psel),
    .Penable   (Penable),
    .Pwrite    (Pwrite),
    .Paddr     (Paddr),
    .Pwdata    (Pwdata),
    .Prdata    (Prdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] trans, input logic [31:0] addr, input logic wr);
    Htrans = trans;
    Haddr  = addr;
    Hwrite = wr;
  endtask

  task automatic idle_bus();
    drive(2'b00, 32'h0, 1'b0);
  endtask

  initial begin
    Hrst     = 1'b1;
    Hreadyin = 1'b1;
    Hsize    = 3'b010;
    Hburst   = 3'b000;
    Hwdata   = 32'h0;
    Prdata   = 32'h0;
    idle_bus();
    #12;
    check_eq("rst_psel", 32'(Psel), 32'h0);
    check_eq("rst_penable", 32'(Penable), 32'h0);
    check_eq("rst_pwrite", 32'(Pwrite), 32'h0);
    check_eq("rst_paddr", Paddr, 32'h0);
    check_eq("rst_pwdata", Pwdata, 32'h0);
    check_eq("rst_hready", 32'(Hreadyout), 32'h1);
    check_eq("rst_hresp", 32'(Hresp), 32'h0);
    Hrst = 1'b0;
    tick();

    // Single write: address phase, then WWAIT, WRITE, WENABLE.
    drive(2'b10, 32'h8000_0010, 1'b1);
    tick();
    check_eq("wr_wwait_hready", 32'(Hreadyout), 32'h0);
    check_eq("wr_wwait_psel", 32'(Psel), 32'h0);
    idle_bus();
    Hwdata = 32'hDEAD_BEEF;
    tick();
    Hwdata = 32'h0;
    check_eq("wr_setup_psel", 32'(Psel), 32'h1);
    check_eq("wr_setup_paddr", Paddr, 32'h8000_0010);
    check_eq("wr_setup_pwdata", Pwdata, 32'hDEAD_BEEF);
    check_eq("wr_setup_pwrite", 32'(Pwrite), 32'h1);
    check_eq("wr_setup_penable", 32'(Penable), 32'h0);
    check_eq("wr_setup_hready", 32'(Hreadyout), 32'h0);
    tick();
    check_eq("wr_en_penable", 32'(Penable), 32'h1);
    check_eq("wr_en_hready", 32'(Hreadyout), 32'h1);
    check_eq("wr_en_psel", 32'(Psel), 32'h1);
    check_eq("wr_en_pwdata", Pwdata, 32'hDEAD_BEEF);
    tick();
    check_eq("wr_done_psel", 32'(Psel), 32'h0);
    check_eq("wr_done_penable", 32'(Penable), 32'h0);

    // Single read in slot 1.
    Prdata = 32'h1234_5678;
    drive(2'b10, 32'h8400_0004, 1'b0);
    tick();
    idle_bus();
    check_eq("rd_setup_psel", 32'(Psel), 32'h2);
    check_eq("rd_setup_pwrite", 32'(Pwrite), 32'h0);
    check_eq("rd_setup_penable", 32'(Penable), 32'h0);
    check_eq("rd_setup_hready", 32'(Hreadyout), 32'h0);
    check_eq("rd_setup_paddr", Paddr, 32'h8400_0004);
    tick();
    check_eq("rd_en_penable", 32'(Penable), 32'h1);
    check_eq("rd_en_hready", 32'(Hreadyout), 32'h1);
    check_eq("rd_en_hrdata", Hrdata, 32'h1234_5678);
    tick();
    check_eq("rd_done_psel", 32'(Psel), 32'h0);
    Prdata = 32'hA5A5_0F0F;
    #1;
    check_eq("hrdata_passthru", Hrdata, 32'hA5A5_0F0F);

    // Back-to-back: read slot 2, write slot 3, read slot 0.
    drive(2'b10, 32'h8800_0000, 1'b0);
    tick();
    idle_bus();
    check_eq("b2b_rd_psel", 32'(Psel), 32'h4);
    tick();
    check_eq("b2b_rd_en", 32'(Penable), 32'h1);
    drive(2'b10, 32'h8C00_0000, 1'b1);
    tick();
    idle_bus();
    Hwdata = 32'hCAFE_0001;
    check_eq("b2b_wwait_hready", 32'(Hreadyout), 32'h0);
    tick();
    check_eq("b2b_wr_psel", 32'(Psel), 32'h8);
    check_eq("b2b_wr_pwdata", Pwdata, 32'hCAFE_0001);
    tick();
    check_eq("b2b_wr_en", 32'(Penable), 32'h1);
    drive(2'b11, 32'h8000_0008, 1'b0);
    tick();
    idle_bus();
    check_eq("b2b_rd2_psel", 32'(Psel), 32'h1);
    check_eq("b2b_rd2_penable", 32'(Penable), 32'h0);
    check_eq("b2b_rd2_paddr", Paddr, 32'h8000_0008);
    tick();
    tick();

    // Top-of-region address decodes to slot 3.
    drive(2'b10, 32'h8FFF_FFFC, 1'b0);
    tick();
    idle_bus();
    check_eq("top_slot_psel", 32'(Psel), 32'h8);
    tick();
    tick();

    // BUSY and Hreadyin=0 are ignored.
    drive(2'b01, 32'h8000_0000, 1'b0);
    tick();
    check_eq("busy_psel", 32'(Psel), 32'h0);
    check_eq("busy_hready", 32'(Hreadyout), 32'h1);
    drive(2'b10, 32'h8000_0000, 1'b1);
    Hreadyin = 1'b0;
    tick();
    check_eq("nordy_psel", 32'(Psel), 32'h0);
    check_eq("nordy_hready", 32'(Hreadyout), 32'h1);
    Hreadyin = 1'b1;
    idle_bus();
    tick();
    check_eq("nordy_after_psel", 32'(Psel), 32'h0);

    // Below and above the region.
    drive(2'b10, 32'h7FFF_FFFC, 1'b0);
    tick();
    idle_bus();
    check_eq("below_psel", 32'(Psel), 32'h0);
`ifdef ERR_RESP_EN
    tick();
    tick();
`endif
    drive(2'b10, 32'h9000_0000, 1'b0);
    tick();
    idle_bus();
    check_eq("oor_psel", 32'(Psel), 32'h0);
`ifdef ERR_RESP_EN
    check_eq("oor_err1_hresp", 32'(Hresp), 32'h1);
    check_eq("oor_err1_hready", 32'(Hreadyout), 32'h0);
    tick();
    check_eq("oor_err2_hresp", 32'(Hresp), 32'h1);
    check_eq("oor_err2_hready", 32'(Hreadyout), 32'h1);
    tick();
    check_eq("oor_end_hresp", 32'(Hresp), 32'h0);
    check_eq("oor_end_psel", 32'(Psel), 32'h0);
`else
    check_eq("oor_hresp", 32'(Hresp), 32'h0);
    check_eq("oor_hready", 32'(Hreadyout), 32'h1);
    tick();
    check_eq("oor_after_psel", 32'(Psel), 32'h0);
`endif
    tick();

    // Asynchronous reset while in WRITE.
    drive(2'b10, 32'h8400_0020, 1'b1);
    tick();
    idle_bus();
    Hwdata = 32'h5555_AAAA;
    tick();
    check_eq("arst_pre_psel", 32'(Psel), 32'h2);
    #2;
    Hrst = 1'b1;
    #1;
    check_eq("arst_psel", 32'(Psel), 32'h0);
    check_eq("arst_penable", 32'(Penable), 32'h0);
    check_eq("arst_hready", 32'(Hreadyout), 32'h1);
    check_eq("arst_pwdata", Pwdata, 32'h0);
    tick();
    Hrst = 1'b0;
    tick();
    check_eq("arst_idle_psel", 32'(Psel), 32'h0);
    drive(2'b10, 32'h8800_0040, 1'b0);
    tick();
    idle_bus();
    check_eq("arst_next_psel", 32'(Psel), 32'h4);
    check_eq("arst_next_hready", 32'(Hreadyout), 32'h0);
    tick();
    check_eq("arst_next_en", 32'(Penable), 32'h1);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
